// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus a four-state qualify FSM. A new level is accepted only after it holds for STABLE_CYCLES clocks.
// Latency: a raw change first sampled at edge k reaches db_level at edge k+2+STABLE_CYCLES. No backpressure applies.
module switch_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic db_level,
  output logic busy
);

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q;
  logic             sw_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_level_q, db_level_d;
  logic             busy_q, busy_d;

  // Any reversal inside a WAIT state returns to the prior stable state.
  // The counter then restarts from zero, so no partial credit carries over.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (sw_s_q) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sw_s_q) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s_q) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sw_s_q) begin
          state_d = ONE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ZERO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state, so they track state_q exactly.
  always_comb begin
    db_level_d = (state_d == ONE) || (state_d == WAIT0);
    busy_d     = (state_d == WAIT1) || (state_d == WAIT0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sw_s_q     <= 1'b0;
      state_q    <= ZERO;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sw_raw;
      sw_s_q     <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      busy_q     <= busy_d;
    end
  end

  assign db_level = db_level_q;
  assign busy     = busy_q;

endmodule
